// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and default constants for the SRAM word controller
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int unsigned DEF_WAIT_CYCLES = 5;
    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_SRAM_AW     = 18;

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - MEM-stage word request bus between the pipeline and the SRAM controller
interface sram_ctrl_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - per-phase wait counter, wraps to zero on its last count
module sram_phase_timer
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned CW          = $clog2(WAIT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          run,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = run && (count == CW'(WAIT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || last) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit word access over a 16-bit SRAM in two timed phases
// Optional address range checking with addr_err: SRAM_CTRL_ADDR_CHECK_EN
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_if.slave         mem,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES);
    localparam int unsigned IW = SRAM_AW - 1;

    state_t        state;
    state_t        state_next;
    op_t           op_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   read_data;
    logic [IW-1:0] index;
    logic [CW-1:0] count;
    logic          last;
    logic          run;
    logic          hi;
    logic          req;
    logic          ready;

    assign req   = mem.rd_en | mem.wr_en;
    assign run   = (state == ST_LO) || (state == ST_HI);
    assign hi    = (state == ST_HI);
    assign index = IW'((addr_q - BASE_ADDR) >> 2);

    assign mem.ready     = ready;
    assign mem.read_data = read_data;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    logic bad;
    logic err_q;
    assign bad = (mem.address < BASE_ADDR) || (mem.address[1:0] != 2'b00) ||
                 (((mem.address - BASE_ADDR) >> 2) >= (32'd1 << IW));
`endif

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CW          (CW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (~run),
        .run   (run),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
`ifdef SRAM_CTRL_ADDR_CHECK_EN
                    state_next = bad ? ST_DONE : ST_LO;
`else
                    state_next = ST_LO;
`endif
                end
            end
            ST_LO:   if (last) state_next = ST_HI;
            ST_HI:   if (last) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // SRAM pins decode from registered state only; ready alone looks at the live request
    always_comb begin
        ready      = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        addr_err   = 1'b0;
`endif
        case (state)
            ST_IDLE: ready = ~req;
            ST_LO, ST_HI: begin
                sram_addr = {index, hi};
                if (op_q == OP_WRITE) begin
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = hi ? wdata_q[31:16] : wdata_q[15:0];
                    sram_we_n  = ~(count < CW'(WAIT_CYCLES - 1));
                end
            end
            default: begin
                ready = 1'b1;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
                addr_err = err_q;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            op_q      <= OP_READ;
            read_data <= '0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            if ((state == ST_IDLE) && req) begin
                addr_q  <= mem.address;
                wdata_q <= mem.write_data;
                op_q    <= mem.wr_en ? OP_WRITE : OP_READ;
            end
            if ((op_q == OP_READ) && last) begin
                if (hi) begin
                    read_data[31:16] <= sram_dq_i;
                end else begin
                    read_data[15:0] <= sram_dq_i;
                end
            end
`ifdef SRAM_CTRL_ADDR_CHECK_EN
            err_q <= (state == ST_IDLE) && req && bad;
`endif
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl with a small SRAM model
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    logic        addr_err;
    logic        err_h [0:12];
`endif

    logic [15:0] model [0:63];
    logic        rdy_h [0:12];
    logic        we_h  [0:12];
    logic        oe_h  [0:12];
    logic [17:0] addr_h [0:12];
    logic [15:0] dqo_h [0:12];
    logic [31:0] rd_h  [0:12];

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    sram_ctrl_if mem_bus ();

    sram_ctrl #(
        .WAIT_CYCLES (5),
        .BASE_ADDR   (1024),
        .SRAM_AW     (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mem_bus),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        ,
        .addr_err   (addr_err)
`endif
    );

    always #5 clk = ~clk;

    assign sram_dq_i = model[sram_addr[5:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) model[sram_addr[5:0]] <= sram_dq_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sample(input int c);
        rdy_h[c]  = mem_bus.ready;
        we_h[c]   = sram_we_n;
        oe_h[c]   = sram_dq_oe;
        addr_h[c] = sram_addr;
        dqo_h[c]  = sram_dq_o;
        rd_h[c]   = mem_bus.read_data;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        err_h[c]  = addr_err;
`endif
    endtask

    // Request presented at a falling edge (cycle 0), dropped and scrambled from cycle 1 on
    task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_bus.rd_en      = r;
        mem_bus.wr_en      = w;
        mem_bus.address    = a;
        mem_bus.write_data = d;
        #1;
        sample(0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1) begin
                mem_bus.rd_en      = 1'b0;
                mem_bus.wr_en      = 1'b0;
                mem_bus.address    = 32'hFFFF_FFF0;
                mem_bus.write_data = 32'h0;
            end
        end
    endtask

    function automatic int we_low(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (we_h[i] == 1'b0) n++;
        return n;
    endfunction

    function automatic int oe_high(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (oe_h[i] == 1'b1) n++;
        return n;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 16'h0;
        mem_bus.rd_en      = 1'b0;
        mem_bus.wr_en      = 1'b0;
        mem_bus.address    = 32'h0;
        mem_bus.write_data = 32'h0;
        repeat (2) @(negedge clk);

        check("rst_ready", mem_bus.ready, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_rdata", mem_bus.read_data, 0);
        rst = 1'b0;

        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_bus.ready && sram_we_n && !sram_dq_oe) cnt++;
        end
        check("idle_quiet", cnt, 3);

        do_access(1'b0, 1'b1, 32'd1028, 32'h1234_5678);
        cnt = 0;
        for (int i = 0; i <= 11; i++) if (!rdy_h[i]) cnt++;
        check("wr_ready_low", cnt, 11);
        check("wr_ready_done", rdy_h[11], 1);
        check("wr_ready_after", rdy_h[12], 1);
        check("wr_lo_addr", addr_h[1], 2);
        check("wr_lo_data", dqo_h[1], 32'h5678);
        check("wr_lo_we_low", we_low(1, 5), 4);
        check("wr_lo_hold", we_h[5], 1);
        check("wr_hi_addr", addr_h[6], 3);
        check("wr_hi_data", dqo_h[6], 32'h1234);
        check("wr_hi_we_low", we_low(6, 10), 4);
        check("wr_oe_phases", oe_high(0, 12), 10);
        check("wr_done_addr", addr_h[11], 0);
        check("wr_mem_lo", model[2], 32'h5678);
        check("wr_mem_hi", model[3], 32'h1234);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        check("wr_no_err", err_h[11], 0);
`endif

        do_access(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
        check("rd_data_done", rd_h[11], 32'h1234_5678);
        check("rd_ready_done", rdy_h[11], 1);
        check("rd_no_we", we_low(0, 12), 0);
        check("rd_no_oe", oe_high(0, 12), 0);
        check("rd_addr_hi", addr_h[6], 3);

        do_access(1'b1, 1'b1, 32'd1032, 32'hCAFE_BABE);
        check("both_oe", oe_h[1], 1);
        check("both_lo_addr", addr_h[2], 4);
        check("both_hi_addr", addr_h[9], 5);
        check("both_mem_lo", model[4], 32'hBABE);
        check("both_mem_hi", model[5], 32'hCAFE);
        check("wr_keeps_rdata", rd_h[12], 32'h1234_5678);

        do_access(1'b1, 1'b0, 32'd1032, 32'h0);
        check("rd2_data", rd_h[11], 32'hCAFE_BABE);

`ifndef SRAM_CTRL_ADDR_CHECK_EN
        do_access(1'b1, 1'b0, 32'd525316, 32'h0);
        check("wrap_addr", addr_h[1], 2);
        check("wrap_data", rd_h[11], 32'h1234_5678);
`endif

        mem_bus.wr_en      = 1'b1;
        mem_bus.address    = 32'd1036;
        mem_bus.write_data = 32'hAAAA_5555;
        @(negedge clk);
        mem_bus.wr_en = 1'b0;
        repeat (6) @(negedge clk);
        check("hi_we_low", sram_we_n, 0);
        check("hi_addr", sram_addr, 7);
        #2 rst = 1'b1;
        #1;
        check("arst_we_n", sram_we_n, 1);
        check("arst_oe", sram_dq_oe, 0);
        check("arst_addr", sram_addr, 0);
        check("arst_ready", mem_bus.ready, 1);
        check("arst_rdata", mem_bus.read_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", mem_bus.ready, 1);

        mem_bus.rd_en   = 1'b1;
        mem_bus.address = 32'd1028;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 11) begin
                check("b2b_done_ready", mem_bus.ready, 1);
                check("b2b_done_data", mem_bus.read_data, 32'h1234_5678);
            end
            if (c == 12) begin
                check("b2b_idle_ready", mem_bus.ready, 0);
                check("b2b_idle_addr", sram_addr, 0);
            end
            if (c == 13) begin
                check("b2b_lo_addr", sram_addr, 2);
                mem_bus.rd_en = 1'b0;
            end
        end
        repeat (12) @(negedge clk);
        check("b2b_end_ready", mem_bus.ready, 1);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
        begin
            logic [31:0] bad_addr [0:2];
            bad_addr[0] = 32'd512;
            bad_addr[1] = 32'd1030;
            bad_addr[2] = 32'd525316;
            for (int k = 0; k < 3; k++) begin
                do_access(1'b1, 1'b0, bad_addr[k], 32'h0);
                check("err_ready_c0", rdy_h[0], 0);
                check("err_ready_c1", rdy_h[1], 1);
                check("err_flag_c1", err_h[1], 1);
                check("err_flag_c2", err_h[2], 0);
                check("err_no_we", we_low(0, 12), 0);
                check("err_no_addr", addr_h[1], 0);
                check("err_rdata", rd_h[1], 32'h1234_5678);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
